// File: rtl/dma_csr.sv
// rtl/dma_csr.sv - DMA control/status register block with launch/track FSM
// CPU-visible SRC/DST/LEN/CTRL/STATUS/COUNT registers driving the DMA engine command inputs.
module dma_csr #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              bus_err,
  output logic              dma_start,
  output logic [31:0]       dma_src_addr,
  output logic [31:0]       dma_dst_addr,
  output logic [LEN_W-1:0]  dma_word_length,
  input  logic              dma_busy,
  input  logic              dma_done,
  output logic              irq
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  localparam int WSEL_W = ADDR_W - 2;
  localparam logic [WSEL_W-1:0] R_SRC    = WSEL_W'(0);
  localparam logic [WSEL_W-1:0] R_DST    = WSEL_W'(1);
  localparam logic [WSEL_W-1:0] R_LEN    = WSEL_W'(2);
  localparam logic [WSEL_W-1:0] R_CTRL   = WSEL_W'(3);
  localparam logic [WSEL_W-1:0] R_STATUS = WSEL_W'(4);
  localparam logic [WSEL_W-1:0] R_COUNT  = WSEL_W'(5);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [31:0]       src_q;
  logic [31:0]       dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic              irq_en_q;
  logic              done_q;
  logic              err_q;

  logic [WSEL_W-1:0] wsel;
  logic              access;
  logic              wr;
  logic              busy;
  logic              mapped;
  logic              cfg_sel;
  logic              start_req;
  logic              launch;
  logic              start_err;
  logic              cfg_block;
  logic              set_err;
  logic              set_done;
  logic              clr_done;
  logic              clr_err;
  logic [31:0]       rd_val;
  logic              unused_ok;

  // A request seen while bus_ready is high is the tail of an access already served.
  assign wsel      = bus_addr[ADDR_W-1:2];
  assign access    = bus_req & ~bus_ready;
  assign wr        = access & bus_we;
  assign busy      = (state != S_IDLE);
  assign mapped    = (wsel <= R_COUNT);
  assign cfg_sel   = (wsel == R_SRC) | (wsel == R_DST) | (wsel == R_LEN);

  assign start_req = wr & (wsel == R_CTRL) & bus_wdata[0];
  assign launch    = start_req & ~busy & (len_q != '0);
  assign start_err = start_req & ~launch;
  assign cfg_block = wr & cfg_sel & busy;
  assign set_err   = start_err | cfg_block;
  assign set_done  = (state == S_RUN) & dma_done;
  assign clr_done  = wr & (wsel == R_STATUS) & bus_wdata[1];
  assign clr_err   = wr & (wsel == R_STATUS) & bus_wdata[2];

  assign irq             = irq_en_q & (done_q | err_q);
  assign dma_src_addr    = src_q;
  assign dma_dst_addr    = dst_q;
  assign dma_word_length = len_q;

  // Engine busy is informational only; address byte lanes are not decoded.
  assign unused_ok = ^{dma_busy, bus_addr[1:0]};

  always_comb begin
    rd_val = '0;
    case (wsel)
      R_SRC:    rd_val = src_q;
      R_DST:    rd_val = dst_q;
      R_LEN:    rd_val = 32'(len_q);
      R_CTRL:   rd_val = {30'd0, irq_en_q, 1'b0};
      R_STATUS: rd_val = {29'd0, err_q, done_q, busy};
      R_COUNT:  rd_val = 32'(count_q);
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (launch) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    if (dma_done) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= access;
      bus_err   <= access & (~mapped | set_err);
      bus_rdata <= (access & ~bus_we) ? rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr & ~busy) begin
        case (wsel)
          R_SRC:   src_q <= bus_wdata;
          R_DST:   dst_q <= bus_wdata;
          R_LEN:   len_q <= bus_wdata[LEN_W-1:0];
          default: ;
        endcase
      end
      if (wr & (wsel == R_CTRL)) irq_en_q <= bus_wdata[1];
    end
  end

  // Set terms are OR-ed after the clear so a coincident set always survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dma_start <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state     <= state_nx;
      dma_start <= (state == S_LAUNCH);
      done_q    <= set_done | (done_q & ~clr_done);
      err_q     <= set_err | (err_q & ~clr_err);
      if (set_done) count_q <= count_q + LEN_W'(1);
    end
  end

endmodule
